// File: rtl/handshake_fifo.sv
// handshake_fifo: first-word-fall-through valid/ready FIFO with level and almost-full; optional stats via HANDSHAKE_FIFO_STATS_EN
module handshake_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_BITS-1:0]       s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_BITS-1:0]       m_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       almost_full
`ifdef HANDSHAKE_FIFO_STATS_EN
  ,
  output logic [31:0]                push_count,
  output logic [31:0]                pop_count,
  output logic [$clog2(DEPTH):0]     max_level
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [AW:0] r_wptr, r_rptr, r_level, w_level_nxt;
  logic w_empty, w_full, w_push, w_pop;
  assign w_empty = r_wptr == r_rptr;
  assign w_full = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  // rst gates s_ready so nothing is offered as accepted during the reset cycle
  assign s_ready = !w_full && !rst;
  assign m_valid = !w_empty;
  assign m_data = r_mem[r_rptr[AW-1:0]];
  assign w_push = s_valid && s_ready;
  assign w_pop = m_valid && m_ready;
  assign w_level_nxt = r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
  assign level = r_level;
  assign almost_full = r_level >= (AW+1)'(AFULL_THRESH);
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr[AW-1:0]] <= s_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_level <= '0;
    end else begin
      r_wptr <= r_wptr + {{AW{1'b0}}, w_push};
      r_rptr <= r_rptr + {{AW{1'b0}}, w_pop};
      r_level <= w_level_nxt;
    end
  end
`ifdef HANDSHAKE_FIFO_STATS_EN
  logic [31:0] r_push_count, r_pop_count;
  logic [AW:0] r_max_level;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_push_count <= '0;
      r_pop_count <= '0;
      r_max_level <= '0;
    end else begin
      r_push_count <= r_push_count + {31'd0, w_push};
      r_pop_count <= r_pop_count + {31'd0, w_pop};
      r_max_level <= (w_level_nxt > r_max_level) ? w_level_nxt : r_max_level;
    end
  end
  assign push_count = r_push_count;
  assign pop_count = r_pop_count;
  assign max_level = r_max_level;
`endif
endmodule

// File: tb/tb_handshake_fifo.sv
// tb_handshake_fifo: directed vector table plus scoreboard sequences for handshake_fifo
module tb_handshake_fifo;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, s_valid = 0, m_ready = 0;
  logic [7:0] s_data = 0;
  logic s_ready, m_valid, almost_full;
  logic [7:0] m_data;
  logic [2:0] level;
`ifdef HANDSHAKE_FIFO_STATS_EN
  logic [31:0] push_count, pop_count;
  logic [2:0] max_level;
`endif
  handshake_fifo #(.DATA_BITS(8), .DEPTH(DEPTH), .AFULL_THRESH(2)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .level(level),
    .almost_full(almost_full)
`ifdef HANDSHAKE_FIFO_STATS_EN
    , .push_count(push_count), .pop_count(pop_count), .max_level(max_level)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rst, sv, mr;
    logic [7:0] d;
    logic sr, mv, af;
    logic [7:0] md;
    logic [2:0] lv;
  } vec_t;
  vec_t v [29];
  int checks = 0, errors = 0;
  logic [7:0] q [$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic vec_t mk(logic r, logic sv, logic [7:0] d, logic mr, logic sr, logic mv, logic [7:0] md, logic [2:0] lv, logic af);
    vec_t t;
    t.rst = r; t.sv = sv; t.d = d; t.mr = mr; t.sr = sr; t.mv = mv; t.md = md; t.lv = lv; t.af = af;
    return t;
  endfunction
  task automatic step(input logic sv, input logic [7:0] d, input logic mr);
    logic push, pop;
    @(negedge clk);
    s_valid = sv; s_data = d; m_ready = mr;
    #1;
    chk("sb_level", {29'd0, level}, q.size());
    chk("sb_m_valid", {31'd0, m_valid}, {31'd0, q.size() != 0});
    chk("sb_s_ready", {31'd0, s_ready}, {31'd0, q.size() < DEPTH});
    if (q.size() != 0) chk("sb_m_data", {24'd0, m_data}, {24'd0, q[0]});
    push = sv && q.size() < DEPTH;
    pop = mr && q.size() != 0;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) q.push_back(d);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1; s_valid = 0; m_ready = 0;
    #1;
    chk("rst_s_ready", {31'd0, s_ready}, 0);
    @(posedge clk);
    q.delete();
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    int pushes, cyc;
    v[0]  = mk(1,0,8'h00,0, 0,0,8'h00,0,0);
    v[1]  = mk(0,1,8'hA5,0, 1,0,8'h00,0,0);
    v[2]  = mk(0,0,8'h00,0, 1,1,8'hA5,1,0);
    v[3]  = mk(0,0,8'h00,1, 1,1,8'hA5,1,0);
    v[4]  = mk(0,0,8'h00,0, 1,0,8'h00,0,0);
    v[5]  = mk(0,1,8'h01,0, 1,0,8'h00,0,0);
    v[6]  = mk(0,1,8'h02,0, 1,1,8'h01,1,0);
    v[7]  = mk(0,1,8'h03,0, 1,1,8'h01,2,1);
    v[8]  = mk(0,1,8'h04,0, 1,1,8'h01,3,1);
    v[9]  = mk(0,1,8'h05,0, 0,1,8'h01,4,1);
    v[10] = mk(0,1,8'h05,1, 0,1,8'h01,4,1);
    v[11] = mk(0,1,8'h05,0, 1,1,8'h02,3,1);
    v[12] = mk(0,0,8'h00,1, 0,1,8'h02,4,1);
    v[13] = mk(0,0,8'h00,1, 1,1,8'h03,3,1);
    v[14] = mk(0,0,8'h00,1, 1,1,8'h04,2,1);
    v[15] = mk(0,0,8'h00,1, 1,1,8'h05,1,0);
    v[16] = mk(0,0,8'h00,0, 1,0,8'h00,0,0);
    v[17] = mk(0,1,8'h11,0, 1,0,8'h00,0,0);
    v[18] = mk(0,1,8'h22,0, 1,1,8'h11,1,0);
    v[19] = mk(0,1,8'h33,0, 1,1,8'h11,2,1);
    v[20] = mk(1,0,8'h00,0, 0,1,8'h11,3,1);
    v[21] = mk(0,1,8'hC4,0, 1,0,8'h00,0,0);
    v[22] = mk(0,0,8'h00,0, 1,1,8'hC4,1,0);
    v[23] = mk(0,0,8'h00,1, 1,1,8'hC4,1,0);
    v[24] = mk(0,0,8'h00,0, 1,0,8'h00,0,0);
    v[25] = mk(0,1,8'h66,1, 1,0,8'h00,0,0);
    v[26] = mk(0,1,8'h77,1, 1,1,8'h66,1,0);
    v[27] = mk(0,0,8'h00,1, 1,1,8'h77,1,0);
    v[28] = mk(0,0,8'h00,0, 1,0,8'h00,0,0);
    @(posedge clk);
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      rst = v[i].rst; s_valid = v[i].sv; s_data = v[i].d; m_ready = v[i].mr;
      #1;
      chk($sformatf("v%0d_s_ready", i), {31'd0, s_ready}, {31'd0, v[i].sr});
      chk($sformatf("v%0d_m_valid", i), {31'd0, m_valid}, {31'd0, v[i].mv});
      chk($sformatf("v%0d_level", i), {29'd0, level}, {29'd0, v[i].lv});
      chk($sformatf("v%0d_almost_full", i), {31'd0, almost_full}, {31'd0, v[i].af});
      if (v[i].mv) chk($sformatf("v%0d_m_data", i), {24'd0, m_data}, {24'd0, v[i].md});
      @(posedge clk);
    end
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 100; i++) step(1'b1, 8'(i), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    pushes = 0;
    cyc = 0;
    while (pushes < 10000 && cyc < 60000) begin
      logic sv, mr;
      logic [7:0] d;
      sv = 1'($urandom_range(0, 1));
      mr = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      if (sv && q.size() < DEPTH) pushes++;
      step(sv, d, mr);
      cyc++;
    end
    chk("random_budget", {31'd0, pushes >= 10000}, 1);
`ifdef HANDSHAKE_FIFO_STATS_EN
    do_reset();
    #1;
    chk("stats_push_rst", push_count, 0);
    chk("stats_pop_rst", pop_count, 0);
    chk("stats_max_rst", {29'd0, max_level}, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(i + 4), 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    s_valid = 0; m_ready = 0;
    #1;
    chk("stats_push", push_count, 7);
    chk("stats_pop", pop_count, 5);
    chk("stats_max", {29'd0, max_level}, 4);
    do_reset();
    #1;
    chk("stats_push_clr", push_count, 0);
    chk("stats_pop_clr", pop_count, 0);
    chk("stats_max_clr", {29'd0, max_level}, 0);
`else
    do_reset();
`endif
    step(1'b0, 8'h00, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
